// File: rtl/cpu8080_intc_pkg.sv
// cpu8080_intc_pkg: shared constants, state type and vector helper for the
// cpu8080 vectored interrupt controller.
package cpu8080_intc_pkg;

  localparam int unsigned NUM_IRQ         = 8;
  localparam int unsigned VEC_W           = 3;
  localparam logic [7:0]  RST_BASE        = 8'hC7;
  localparam logic [7:0]  SPURIOUS_VEC    = 8'hFF;
  localparam logic [7:0]  IMR_OFS         = 8'd0;
  localparam logic [7:0]  ISR_OFS         = 8'd1;
  localparam int unsigned EOI_NONSPEC_BIT = 7;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  // RST n opcode: 11nnn111
  function automatic logic [7:0] rst_opcode(input logic [VEC_W-1:0] n);
    return RST_BASE | {2'b00, n, 3'b000};
  endfunction

endpackage

// File: rtl/cpu8080_intc_prio.sv
// cpu8080_intc_prio: combinational eligibility filter and priority encoder.
// Ports:
//   i_irr, i_imr, i_isr : pending, mask and in-service vectors
//   o_valid             : some request is eligible
//   o_index             : lowest eligible index (index 0 = highest priority)
module cpu8080_intc_prio
  import cpu8080_intc_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_irr,
  input  logic [NUM_IRQ-1:0] i_imr,
  input  logic [NUM_IRQ-1:0] i_isr,
  output logic               o_valid,
  output logic [VEC_W-1:0]   o_index
);

  logic [NUM_IRQ-1:0] w_isr_low;
  logic [NUM_IRQ-1:0] w_below;
  logic [NUM_IRQ-1:0] w_elig;

  // Isolate the highest-priority in-service bit; minus one gives the mask of
  // strictly higher priorities (all ones when nothing is in service).
  assign w_isr_low = i_isr & (~i_isr + 8'd1);
  assign w_below   = w_isr_low - 8'd1;
  assign w_elig    = i_irr & ~i_imr & w_below;

  always_comb begin
    o_valid = |w_elig;
    o_index = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (w_elig[i]) o_index = VEC_W'(i);
    end
  end

endmodule

// File: rtl/cpu8080_intc.sv
// cpu8080_intc: 8-input vectored interrupt controller for the cpu8080 core.
// Latches irq rising edges, raises o_intr, answers inta with an RST n opcode,
// and exposes IMR (BASE_PORT) and ISR/EOI (BASE_PORT+1) on the I/O bus.
// Optional build macro CPU8080_INTC_AUTO_EOI_EN: acknowledge never sets ISR,
// EOI writes are ignored.
// Ports:
//   i_clock, i_reset      : clock, synchronous active-high reset
//   i_addr, i_data_in     : I/O port number and write data
//   o_data_out, o_data_oe : read / vector data and its bus enable
//   i_readio, i_writeio   : I/O strobes
//   i_inta, o_intr        : acknowledge in, interrupt request out
//   i_irq                 : synchronous rising-edge peripheral requests
module cpu8080_intc
  import cpu8080_intc_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'h20
)(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [7:0]         i_addr,
  input  logic [7:0]         i_data_in,
  output logic [7:0]         o_data_out,
  output logic               o_data_oe,
  input  logic               i_readio,
  input  logic               i_writeio,
  input  logic               i_inta,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic               o_intr
);

  localparam logic [7:0] IMR_PORT = 8'(BASE_PORT + IMR_OFS);
  localparam logic [7:0] ISR_PORT = 8'(BASE_PORT + ISR_OFS);

  state_t             r_state, w_state_nxt;
  logic [NUM_IRQ-1:0] r_irq_q, r_irr, r_imr, r_isr;
  logic [7:0]         r_vec;
  logic               r_intr, r_inta_q, r_wr_q;

  logic               w_valid, w_ack, w_wr_edge, w_hit_imr, w_hit_isr;
  logic [VEC_W-1:0]   w_idx;
  logic [NUM_IRQ-1:0] w_rise, w_take, w_isr_set, w_isr_clr;

  assign w_rise    = i_irq & ~r_irq_q;
  assign w_wr_edge = i_writeio & ~r_wr_q;
  assign w_hit_imr = (i_addr == IMR_PORT);
  assign w_hit_isr = (i_addr == ISR_PORT);
  assign o_intr    = r_intr;

  cpu8080_intc_prio u_prio (
    .i_irr   (r_irr),
    .i_imr   (r_imr),
    .i_isr   (r_isr),
    .o_valid (w_valid),
    .o_index (w_idx)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, acknowledge strobe and bus outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    o_data_oe   = 1'b0;
    o_data_out  = 8'h00;
    case (r_state)
      IDLE: begin
        if (i_inta && !r_inta_q) begin
          w_state_nxt = ACK;
          w_ack       = 1'b1;
        end
        if (i_readio && (w_hit_imr || w_hit_isr)) begin
          o_data_oe  = 1'b1;
          o_data_out = w_hit_imr ? r_imr : r_isr;
        end
      end
      ACK: begin
        o_data_oe  = 1'b1;
        o_data_out = r_vec;
        if (!i_inta) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_take = (w_ack && w_valid) ? NUM_IRQ'(8'd1 << w_idx) : '0;

`ifdef CPU8080_INTC_AUTO_EOI_EN
  assign w_isr_set = '0;
  assign w_isr_clr = '0;
`else
  logic [NUM_IRQ-1:0] w_isr_low;
  assign w_isr_low = r_isr & (~r_isr + 8'd1);
  assign w_isr_set = w_take;
  always_comb begin
    w_isr_clr = '0;
    if (w_wr_edge && w_hit_isr) begin
      if (i_data_in[EOI_NONSPEC_BIT]) w_isr_clr = w_isr_low;
      else                            w_isr_clr = NUM_IRQ'(8'd1 << i_data_in[2:0]);
    end
  end
`endif

  // Request, mask, in-service and vector registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_irq_q  <= i_irq;
      r_inta_q <= i_inta;
      r_wr_q   <= i_writeio;
      r_irr    <= '0;
      r_imr    <= '1;
      r_isr    <= '0;
      r_vec    <= 8'h00;
      r_intr   <= 1'b0;
    end else begin
      r_irq_q  <= i_irq;
      r_inta_q <= i_inta;
      r_wr_q   <= i_writeio;
      r_irr    <= (r_irr & ~w_take) | w_rise;
      r_isr    <= (r_isr & ~w_isr_clr) | w_isr_set;
      if (w_wr_edge && w_hit_imr) r_imr <= i_data_in;
      if (w_ack) r_vec <= w_valid ? rst_opcode(w_idx) : SPURIOUS_VEC;
      // Held low for the whole acknowledge
      r_intr   <= w_valid && (w_state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_cpu8080_intc.sv
module tb_cpu8080_intc;

  logic       clk = 1'b0;
  logic       rst, rd, wr, inta;
  logic [7:0] addr, din, irq;
  logic [7:0] dout;
  logic       doe, intr;

  always #5 clk = ~clk;

  cpu8080_intc dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_addr     (addr),
    .i_data_in  (din),
    .o_data_out (dout),
    .o_data_oe  (doe),
    .i_readio   (rd),
    .i_writeio  (wr),
    .i_inta     (inta),
    .i_irq      (irq),
    .o_intr     (intr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_irr, m_imr, m_isr, m_vec, m_irq_q;
  bit         m_ack, m_intr, m_inta_q, m_wr_q;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Eligible request: first unmasked pending line above every in-service line
  function automatic int elig();
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) return -1;
      if (m_irr[i] && !m_imr[i]) return i;
    end
    return -1;
  endfunction

  // Check bus outputs for current inputs, advance model and DUT one clock, check intr
  task automatic tick(input string tag);
    int         n;
    bit         e_oe, ack_e, nxt_ack;
    logic [7:0] e_out, rise, clr;
    #1;
    e_oe  = m_ack || (rd && (addr == 8'h20 || addr == 8'h21));
    e_out = m_ack ? m_vec : (e_oe ? ((addr == 8'h20) ? m_imr : m_isr) : 8'h00);
    check({tag, ".oe"},  {7'b0, doe}, {7'b0, e_oe});
    check({tag, ".out"}, dout, e_out);
    if (rst) begin
      m_irr = 8'h00; m_imr = 8'hFF; m_isr = 8'h00; m_vec = 8'h00;
      m_ack = 1'b0;  m_intr = 1'b0;
    end else begin
      n     = elig();
      rise  = irq & ~m_irq_q;
      ack_e = !m_ack && inta && !m_inta_q;
      clr   = 8'h00;
`ifndef CPU8080_INTC_AUTO_EOI_EN
      if (wr && !m_wr_q && addr == 8'h21) begin
        if (din[7]) begin
          for (int i = 0; i < 8; i++) if (m_isr[i]) begin clr[i] = 1'b1; break; end
        end else begin
          clr[din[2:0]] = 1'b1;
        end
      end
`endif
      m_isr = m_isr & ~clr;
      if (ack_e) begin
        if (n >= 0) begin
          m_vec      = 8'(8'hC7 + 8 * n);
          m_irr[n]   = 1'b0;
`ifndef CPU8080_INTC_AUTO_EOI_EN
          m_isr[n]   = 1'b1;
`endif
        end else begin
          m_vec = 8'hFF;
        end
      end
      m_irr   = m_irr | rise;
      if (wr && !m_wr_q && addr == 8'h20) m_imr = din;
      nxt_ack = m_ack ? inta : ack_e;
      m_ack   = nxt_ack;
      m_intr  = !nxt_ack && (n >= 0);
    end
    m_irq_q  = irq;
    m_inta_q = inta;
    m_wr_q   = wr;
    @(posedge clk);
    #1;
    check({tag, ".intr"}, {7'b0, intr}, {7'b0, m_intr});
  endtask

  task automatic write_port(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1;
    tick("wr");
    wr = 1'b0;
    tick("wr_idle");
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq = v;
    tick("irq_hi");
    irq = 8'h00;
    tick("irq_lo");
  endtask

  // inta high for cyc clocks, vector checked on every held cycle after the first
  task automatic acknowledge(input int cyc, input logic [7:0] exp_vec);
    inta = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      tick("ack");
      if (i < cyc - 1) begin
        check("ack_oe", {7'b0, doe}, 8'h01);
        check("ack_vec", dout, exp_vec);
      end
    end
    inta = 1'b0;
    tick("ack_end");
    check("ack_drop_oe", {7'b0, doe}, 8'h00);
  endtask

  task automatic read_port(input logic [7:0] a, input logic [7:0] exp_v, input bit exp_oe);
    addr = a; rd = 1'b1;
    #1;
    check("rd_oe", {7'b0, doe}, {7'b0, exp_oe});
    check("rd_val", dout, exp_v);
    tick("rd");
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; inta = 1'b0;
    addr = 8'h00; din = 8'h00; irq = 8'h00;
    m_irq_q = 8'h00; m_inta_q = 1'b0; m_wr_q = 1'b0;
    m_irr = 8'h00; m_imr = 8'hFF; m_isr = 8'h00; m_vec = 8'h00;
    m_ack = 1'b0; m_intr = 1'b0;
    tick("rst"); tick("rst");
    rst = 1'b0;
    read_port(8'h20, 8'hFF, 1'b1);
    read_port(8'h21, 8'h00, 1'b1);

    // Masked request stays silent, unmask raises intr one clock later
    irq = 8'h04;
    tick("irq2"); tick("irq2");
    check("masked_intr", {7'b0, intr}, 8'h00);
    addr = 8'h20; din = 8'hFB; wr = 1'b1;
    tick("imr_fb");
    wr = 1'b0;
    tick("imr_fb2");
    check("unmask_intr", {7'b0, intr}, 8'h01);
    irq = 8'h00;
    tick("idle");
    acknowledge(3, 8'hD7);
    check("after_ack_intr", {7'b0, intr}, 8'h00);
`ifndef CPU8080_INTC_AUTO_EOI_EN
    read_port(8'h21, 8'h04, 1'b1);
`endif

    // Nested request and EOI handling
    write_port(8'h20, 8'h00);
    pulse_irq(8'h22);
    tick("nest");
    check("nest_intr", {7'b0, intr}, 8'h01);
    acknowledge(2, 8'hCF);
`ifndef CPU8080_INTC_AUTO_EOI_EN
    read_port(8'h21, 8'h06, 1'b1);
    write_port(8'h21, 8'h80);
    read_port(8'h21, 8'h04, 1'b1);
    check("irq5_blocked", {7'b0, intr}, 8'h00);
    write_port(8'h21, 8'h02);
    read_port(8'h21, 8'h00, 1'b1);
    check("irq5_released", {7'b0, intr}, 8'h01);
    acknowledge(2, 8'hEF);
    // Spurious acknowledge leaves ISR alone
    acknowledge(2, 8'hFF);
    read_port(8'h21, 8'h20, 1'b1);
    write_port(8'h21, 8'h05);
    read_port(8'h21, 8'h00, 1'b1);
`endif

    // Long write strobe performs exactly one write
    addr = 8'h20; din = 8'h0F; wr = 1'b1;
    tick("long_wr");
    din = 8'hAA;
    tick("long_wr"); tick("long_wr"); tick("long_wr");
    wr = 1'b0;
    tick("long_wr_end");
    read_port(8'h20, 8'h0F, 1'b1);
    read_port(8'h22, 8'h00, 1'b0);

    // Reset in the middle of an acknowledge
    write_port(8'h20, 8'h00);
    pulse_irq(8'h01);
    inta = 1'b1;
    tick("ack_r"); tick("ack_r");
    check("pre_rst_oe", {7'b0, doe}, 8'h01);
    rst = 1'b1;
    tick("mid_rst");
    check("rst_oe", {7'b0, doe}, 8'h00);
    rst = 1'b0; inta = 1'b0;
    tick("post_rst");
    read_port(8'h20, 8'hFF, 1'b1);
    read_port(8'h21, 8'h00, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ 8'($urandom_range(0, 255));
      if ($urandom_range(0, 6) == 0) inta = ~inta;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: addr = 8'h20;
          1: addr = 8'h21;
          2: addr = 8'h22;
          default: addr = 8'($urandom_range(0, 255));
        endcase
        din = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 1) << 7 | $urandom_range(0, 7));
        wr  = ($urandom_range(0, 2) == 0);
        rd  = ($urandom_range(0, 1) == 0);
      end
      rst = ($urandom_range(0, 599) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
